// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multi-cycle multiply/divide for the execute stage.
// Shift-add multiply (MUL low word / MULH high word) and restoring divide
// (DIV quotient / REM remainder). Fixed latency of WIDTH iterations, one
// operation in flight, result handed to the register-file write port.
// Optional feature: define MDU_SIGNED_EN to honour is_signed (sign/magnitude
// wrapper around the unsigned core). Without it all operations are unsigned.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic                  is_signed,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic                  wr_en
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [1:0]        op_q;
  // Shared accumulator: multiply keeps {partial product, multiplier},
  // divide keeps {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb_q;     // multiplicand or divisor magnitude
  logic               div_zero;

  // Operand magnitudes presented to the unsigned core at accept.
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

`ifdef MDU_SIGNED_EN
  logic neg_res;   // product / quotient must be negated
  logic neg_rem;   // remainder takes the dividend's sign
  logic a_neg;
  logic b_neg;

  // Sign detection and magnitude conversion of the incoming operands.
  always_comb begin
    a_neg = is_signed & operand_a[WIDTH-1];
    b_neg = is_signed & operand_b[WIDTH-1];
    a_mag = a_neg ? (~operand_a + 1'b1) : operand_a;
    b_mag = b_neg ? (~operand_b + 1'b1) : operand_b;
  end
`else
  logic unused_sign;
  assign unused_sign = is_signed;
  assign a_mag = operand_a;
  assign b_mag = operand_b;
`endif

  // One iteration of each algorithm, computed from the current accumulator.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;

  // Datapath step: shift-add for multiply, trial-subtract-restore for divide.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (div_diff[WIDTH]) begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
    step_next = op_q[1] ? div_next : mul_next;
  end

  // Final result selection from the last iteration, with sign fix-up.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   result_next;

  always_comb begin
    prod = step_next;
    quot = step_next[WIDTH-1:0];
    // With a zero divisor the core shifts the whole dividend into the
    // remainder, so only the quotient needs overriding.
    rem  = step_next[2*WIDTH-1:WIDTH];
`ifdef MDU_SIGNED_EN
    if (neg_res) begin
      prod = ~prod + 1'b1;
      quot = ~quot + 1'b1;
    end
    if (neg_rem) begin
      rem = ~rem + 1'b1;
    end
`endif
    if (div_zero) begin
      quot = '1;
    end
    case (op_q)
      OP_MUL:  result_next = prod[WIDTH-1:0];
      OP_MULH: result_next = prod[2*WIDTH-1:WIDTH];
      OP_DIV:  result_next = quot;
      OP_REM:  result_next = rem;
      default: result_next = '0;
    endcase
  end

  // Control FSM with registered outputs and iteration state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= '0;
      acc      <= '0;
      opb_q    <= '0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      result   <= '0;
      wr_reg   <= '0;
`ifdef MDU_SIGNED_EN
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          if (start && !flush) begin
            state    <= RUN;
            busy     <= 1'b1;
            count    <= '0;
            op_q     <= op;
            acc      <= {{WIDTH{1'b0}}, a_mag};
            opb_q    <= b_mag;
            div_zero <= (operand_b == '0);
            wr_reg   <= rd_in;
`ifdef MDU_SIGNED_EN
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
`endif
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= step_next;
            if (count == LAST) begin
              state  <= DONE;
              result <= result_next;
              done   <= 1'b1;
              wr_en  <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wr_en <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
// An arithmetic reference model tracks expected outputs every cycle;
// directed operations additionally carry hand-computed literal results.
// Honours MDU_SIGNED_EN the same way the design does.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          is_signed = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  operand_a = '0;
  logic [W-1:0]  operand_b = '0;
  logic [4:0]    rd_in = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [4:0]    wr_reg;
  logic          wr_en;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.WIDTH(W), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
    .flush(flush), .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .wr_reg(wr_reg), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic s);
    logic [63:0] p;
    longint sa, sb;
    logic use_signed;
    use_signed = 1'b0;
`ifdef MDU_SIGNED_EN
    use_signed = s;
`else
    if (s) use_signed = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00, 2'b01: begin
        if (use_signed) p = 64'(sa * sb);
        else            p = {32'b0, a} * {32'b0, b};
        return (o == 2'b00) ? p[31:0] : p[63:32];
      end
      2'b10: begin
        if (b == 0) return '1;
        if (use_signed) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
          p = 64'(sa / sb);
          return p[31:0];
        end
        return a / b;
      end
      default: begin
        if (b == 0) return a;
        if (use_signed) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
          p = 64'(sa % sb);
          return p[31:0];
        end
        return a % b;
      end
    endcase
  endfunction

  // Cycle-level expectation: idle / running with a countdown / done pulse.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_result = '0;
  logic [4:0]   m_wr_reg = '0;
  logic [W-1:0] p_res = '0;
  int           remain = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_result = '0; m_wr_reg = '0; remain = 0;
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (flush) begin
        m_busy = 1'b0;
      end else begin
        remain--;
        if (remain == 0) begin
          m_done = 1'b1;
          m_result = p_res;
        end
      end
    end else if (start && !flush) begin
      m_busy = 1'b1;
      remain = W;
      p_res = ref_result(op, operand_a, operand_b, is_signed);
      m_wr_reg = rd_in;
    end
    #1;
    check("model_busy",   64'(busy),   64'(m_busy));
    check("model_done",   64'(done),   64'(m_done));
    check("model_wr_en",  64'(wr_en),  64'(m_done));
    check("model_result", 64'(result), 64'(m_result));
    check("model_wr_reg", 64'(wr_reg), 64'(m_wr_reg));
  end

  // Issue one operation, measure latency and check against a literal result.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [4:0] rd, input logic [W-1:0] exp,
                        input string name, input logic poke_done);
    int n;
    logic got;
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; is_signed = s; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
    check({name, "_latency"}, 64'(n), 64'(32));
    check({name, "_result"},  64'(result), 64'(exp));
    check({name, "_wr_reg"},  64'(wr_reg), 64'(rd));
    check({name, "_wr_en"},   64'(wr_en), 64'(1));
    if (poke_done) begin
      @(negedge clk);
      operand_a = 32'd8; operand_b = 32'd8; op = 2'b00; start = 1'b1;
      @(posedge clk);
      #1;
      check({name, "_done_start_ignored"}, 64'(busy), 64'(0));
      @(negedge clk);
      start = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      check({name, "_busy_after"}, 64'(busy), 64'(0));
      check({name, "_done_after"}, 64'(done), 64'(0));
    end
  endtask

  int pulses;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy",   64'(busy),   64'(0));
    check("reset_result", 64'(result), 64'(0));
    reset = 1'b0;

    run_op(2'b00, 32'd7, 32'd6, 1'b0, 5'd5, 32'd42, "mul_7x6", 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd1, 32'h0000_0001, "mul_ff", 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd2, 32'hFFFF_FFFE, "mulh_ff", 1'b0);
    run_op(2'b10, 32'd100, 32'd7, 1'b0, 5'd3, 32'd14, "div_100_7", 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 5'd4, 32'd2, "rem_100_7", 1'b0);
    run_op(2'b10, 32'h1234, 32'd0, 1'b0, 5'd6, 32'hFFFF_FFFF, "div_by0", 1'b0);
    run_op(2'b11, 32'h1234, 32'd0, 1'b0, 5'd7, 32'h0000_1234, "rem_by0", 1'b0);

    // Flush mid-run, with a stray start while busy.
    @(negedge clk);
    op = 2'b00; operand_a = 32'h1234; operand_b = 32'h55; rd_in = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    operand_a = 32'd11; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_busy", 64'(busy), 64'(0));
    @(negedge clk);
    flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("flush_no_done", 64'(pulses), 64'(0));
    check("flush_result_kept", 64'(result), 64'(32'h1234));
    run_op(2'b00, 32'd3, 32'd3, 1'b0, 5'd10, 32'd9, "mul_3x3", 1'b1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    op = 2'b00; operand_a = 32'd5; operand_b = 32'd5; rd_in = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy",   64'(busy),   64'(0));
    check("arst_done",   64'(done),   64'(0));
    check("arst_wr_en",  64'(wr_en),  64'(0));
    check("arst_result", 64'(result), 64'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b00, 32'd2, 32'd2, 1'b0, 5'd8, 32'd4, "mul_2x2", 1'b0);

`ifdef MDU_SIGNED_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd11, 32'hFFFF_FFFD, "sdiv_m7_2", 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd12, 32'hFFFF_FFFF, "srem_m7_2", 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd13, 32'h8000_0000, "sdiv_ovf", 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd14, 32'h0000_0000, "srem_ovf", 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd15, 32'h0000_0000, "smulh_m1", 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1, 5'd16, 32'hFFFF_FFFF, "sdiv_by0", 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b1, 5'd17, 32'hFFFF_FFF9, "srem_by0", 1'b0);
`else
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd11, 32'h7FFF_FFFC, "udiv_signed_ignored", 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd15, 32'hFFFF_FFFE, "umulh_signed_ignored", 1'b0);
`endif

    // Flush and start together in IDLE: start is dropped.
    @(negedge clk);
    operand_a = 32'd9; operand_b = 32'd9; op = 2'b00; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_start_idle", 64'(busy), 64'(0));
    @(negedge clk);
    start = 1'b0; flush = 1'b0;

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
